fflags_retire_queue: RTL
========================

# fflags_retire_queue

In-order retirement queue for floating-point exception flags. It sits between the FPU issue/completion path and the floating-point CSR file, and tracks every issued FP operation by tag. Operations may complete out of order; their flags are retired strictly in issue order. Each retired non-zero flag set goes to the CSR file as a one-cycle accumulate pulse. CSR instructions that touch fflags or fcsr are stalled until all outstanding FP flags have landed.

## Interface
- DEPTH, 4, number of outstanding FP ops tracked; power of two, ≥ 2; TW = $clog2(DEPTH)
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_flush  input  1  pipeline flush, discards all outstanding entries
- i_issue  input  1  FP op issued this cycle; accepted only when o_issue_ready=1
- o_issue_ready  output  1  queue not full
- o_issue_tag  output  TW  tag assigned to an op issued this cycle (equals write pointer)
- i_done  input  1  FPU completion valid
- i_done_tag  input  TW  tag of completing op
- i_done_fflags  input  5  {nv,dz,of,uf,nx} of completing op
- i_csr_req  input  1  decode holds a CSR instruction addressing 0x001/0x002/0x003
- o_csr_stall  output  1  hold that CSR instruction
- o_fflags_write  output  1  one-cycle pulse: CSR file ORs o_fflags into fflags
- o_fflags  output  5  flags being retired
- o_count  output  TW+1  outstanding entries
- o_tag_err  output  1  sticky: completion for a non-outstanding or already-done tag

## Operation
- Storage: per entry valid, done, flags[4:0]. Pointers wr_ptr and rd_ptr are TW bits wide and wrap modulo DEPTH. count is TW+1 bits.
- Issue:
  - When i_issue && o_issue_ready, entry[wr_ptr] becomes valid=1, done=0, flags=0.
  - wr_ptr increments and count increments.
  - i_issue while full is ignored. No state changes and no error is raised.
- Completion:
  - When i_done, entry[i_done_tag] must be valid and not done. If so, it is set done=1 and its flags are captured.
  - Otherwise the completion is dropped and o_tag_err is set.
- Retire:
  - Each cycle, if entry[rd_ptr] is valid and done, the entry is cleared, rd_ptr increments and count decrements.
  - At the same edge, o_fflags is loaded with the entry flags and o_fflags_write is loaded with (|flags).
  - A zero-flag op retires silently. o_fflags still updates, but o_fflags_write=0.
  - At most one retire per cycle.
- Simultaneous events:
  - Issue and retire in the same cycle: count is unchanged and both pointers advance.
  - Completion and retire in the same cycle: allowed. A completion to the head tag is seen by retire logic only on the next cycle.
- o_issue_ready = (count != DEPTH). It is combinational on registered count and does not look ahead to a same-cycle retire.
- o_csr_stall = i_csr_req && (count != 0 || o_fflags_write). This covers a flag pulse still landing in the CSR file.
- Flush:
  - At the next edge, all valid/done bits clear, both pointers and count go to 0, and o_fflags_write goes to 0. o_fflags and o_tag_err are unchanged.
  - Issue, completion and retire presented in the flush cycle are ignored.
- Reset: state is identical to flush, plus o_fflags=0 and o_tag_err=0.

## Timing
- Reset values: o_issue_ready=1, o_issue_tag=0, o_csr_stall=0 (given i_csr_req=0), o_fflags_write=0, o_fflags=0, o_count=0, o_tag_err=0.
- Completion-to-pulse latency:
  - Completion of the head op sampled at edge E → retire decided in cycle E..E+1 → o_fflags_write high during the cycle after edge E+1.
  - Minimum is 2 edges. A non-head completion waits for all older entries.
- Back-to-back retires sustain 1 per cycle once consecutive entries are done.
- o_fflags_write is a single-cycle registered pulse and never held.
- o_csr_stall deasserts in the cycle after the last pulse (count=0 and o_fflags_write=0).
- Reset asserted mid-operation clears immediately (asynchronously). No pulse is emitted on deassertion.

## Test plan
- Reset, then issue 1 op (tag 0) and complete it with tag 0, flags 5'b00001 → o_fflags_write=1 with o_fflags=00001 exactly 2 edges after completion; o_count returns to 0.
- Issue tags 0,1,2; complete 2 (10000), then 1 (00100), then 0 (00010) → three consecutive pulses in order 00010, 00100, 10000 starting 2 edges after tag 0 completes.
- Fill DEPTH=4 → o_issue_ready=0. An extra i_issue is ignored and o_count stays 4. Wrap around: after 2 retires, 2 new issues get tags 0,1.
- Complete with 5'b00000 → entry retires, o_count decrements, no o_fflags_write. Complete an already-retired tag → o_tag_err=1 and stays 1 until reset.
- Hold i_csr_req with 2 outstanding ops → o_csr_stall=1 until the cycle after the last pulse, then 0.
- Flush with 3 outstanding ops and one completion in the same cycle → next cycle o_count=0, no pulses, o_issue_tag=0. Assert i_rst mid-stream → outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fflags_retire_queue_if.sv
// Signal bundle between the FPU issue/completion path, decode and the fflags retire queue.
// The master side drives issue/completion/CSR requests; the slave side is the queue itself.
interface fflags_retire_queue_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned TW = $clog2(DEPTH);

  logic          i_flush;
  logic          i_issue;
  logic          o_issue_ready;
  logic [TW-1:0] o_issue_tag;
  logic          i_done;
  logic [TW-1:0] i_done_tag;
  logic [4:0]    i_done_fflags;
  logic          i_csr_req;
  logic          o_csr_stall;
  logic          o_fflags_write;
  logic [4:0]    o_fflags;
  logic [TW:0]   o_count;
  logic          o_tag_err;

  modport master (
    output i_flush,
    output i_issue,
    input  o_issue_ready,
    input  o_issue_tag,
    output i_done,
    output i_done_tag,
    output i_done_fflags,
    output i_csr_req,
    input  o_csr_stall,
    input  o_fflags_write,
    input  o_fflags,
    input  o_count,
    input  o_tag_err
  );

  modport slave (
    input  i_flush,
    input  i_issue,
    output o_issue_ready,
    output o_issue_tag,
    input  i_done,
    input  i_done_tag,
    input  i_done_fflags,
    input  i_csr_req,
    output o_csr_stall,
    output o_fflags_write,
    output o_fflags,
    output o_count,
    output o_tag_err
  );
endinterface

// File: rtl/fflags_retire_queue.sv
// In-order retirement of FP exception flags: ops complete out of order by tag, flags are
// retired in issue order as one-cycle accumulate pulses towards the fflags CSR.
module fflags_retire_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  fflags_retire_queue_if.slave bus
);
  localparam int unsigned TW = $clog2(DEPTH);
  localparam logic [TW:0] FullCount = (TW+1)'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [4:0]       flags_q [DEPTH];
  logic [4:0]       flags_d [DEPTH];
  logic [TW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [TW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [TW:0]      count_q, count_d;
  logic [4:0]       fflags_q, fflags_d;
  logic             fflags_write_q, fflags_write_d;
  logic             tag_err_q, tag_err_d;

  logic issue_fire;
  logic done_ok;
  logic retire;

  assign issue_fire = bus.i_issue && (count_q != FullCount);
  assign done_ok    = bus.i_done && valid_q[bus.i_done_tag] && !done_q[bus.i_done_tag];
  // Uses registered done bits, so a same-cycle completion to the head retires next cycle.
  assign retire     = valid_q[rd_ptr_q] && done_q[rd_ptr_q];

  always_comb begin
    valid_d        = valid_q;
    done_d         = done_q;
    flags_d        = flags_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    fflags_d       = fflags_q;
    fflags_write_d = 1'b0;
    tag_err_d      = tag_err_q;

    if (bus.i_flush) begin
      valid_d  = '0;
      done_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Retire, completion and issue never target the same entry in one cycle.
      if (retire) begin
        valid_d[rd_ptr_q] = 1'b0;
        done_d[rd_ptr_q]  = 1'b0;
        flags_d[rd_ptr_q] = '0;
        rd_ptr_d          = rd_ptr_q + 1'b1;
        fflags_d          = flags_q[rd_ptr_q];
        fflags_write_d    = |flags_q[rd_ptr_q];
      end

      if (done_ok) begin
        done_d[bus.i_done_tag]  = 1'b1;
        flags_d[bus.i_done_tag] = bus.i_done_fflags;
      end else if (bus.i_done) begin
        tag_err_d = 1'b1;
      end

      if (issue_fire) begin
        valid_d[wr_ptr_q] = 1'b1;
        done_d[wr_ptr_q]  = 1'b0;
        flags_d[wr_ptr_q] = '0;
        wr_ptr_d          = wr_ptr_q + 1'b1;
      end

      unique case ({issue_fire, retire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q        <= '0;
      done_q         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        flags_q[i] <= '0;
      end
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      fflags_q       <= '0;
      fflags_write_q <= 1'b0;
      tag_err_q      <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      done_q         <= done_d;
      flags_q        <= flags_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      fflags_q       <= fflags_d;
      fflags_write_q <= fflags_write_d;
      tag_err_q      <= tag_err_d;
    end
  end

  assign bus.o_issue_ready  = (count_q != FullCount);
  assign bus.o_issue_tag    = wr_ptr_q;
  // Also stall while the last pulse is still being accumulated into the CSR file.
  assign bus.o_csr_stall    = bus.i_csr_req && ((count_q != '0) || fflags_write_q);
  assign bus.o_fflags_write = fflags_write_q;
  assign bus.o_fflags       = fflags_q;
  assign bus.o_count        = count_q;
  assign bus.o_tag_err      = tag_err_q;
endmodule
